// File: rtl/sd_cmd_sequencer.sv
// SD SPI command sequencer: PRE fill, 6-byte frame, R1 poll, optional 4 data bytes, tail byte; one byte outstanding at a time.
// Accepts a command only in IDLE (cmd_ready), stalls on spi_done per byte; SD_CRC7_EN computes the real CRC7 instead of the fixed table.
module sd_cmd_sequencer #(
  parameter int RESP_POLL_MAX = 16,
  parameter int PRE_BYTES     = 1
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_resp_len,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done,
  output logic        spi_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_FRAME, S_POLL, S_DATA, S_TAIL, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_r1_q, resp_r1_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_timeout_q, resp_timeout_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_tx_q, spi_tx_d;
  logic        spi_cs_n_q, spi_cs_n_d;
  logic        pend_q, pend_d;
  logic        wait_q, wait_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  poll_cnt_q, poll_cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        len_q, len_d;
  logic [7:0]  r1_sh_q, r1_sh_d;
  logic [31:0] data_sh_q, data_sh_d;
  logic        to_sh_q, to_sh_d;

  logic        accept;
  logic        done_ev;
  logic [7:0]  crc_byte;

  assign accept  = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;
  assign done_ev = wait_q && spi_done;

  function automatic logic [7:0] frame_byte(input logic [2:0] n, input logic [5:0] ix,
                                            input logic [31:0] a, input logic [7:0] cb);
    logic [7:0] b;
    case (n)
      3'd0:    b = {2'b01, ix};
      3'd1:    b = a[31:24];
      3'd2:    b = a[23:16];
      3'd3:    b = a[15:8];
      3'd4:    b = a[7:0];
      3'd5:    b = cb;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

`ifdef SD_CRC7_EN
  logic [6:0] crc_q, crc_d;

  // MSB-first serial CRC7, polynomial x^7 + x^3 + 1
  function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] b);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ b[i];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  // Folds each of the first five frame bytes in as it completes on the wire
  always_comb begin
    crc_d = crc_q;
    if (accept) begin
      crc_d = 7'd0;
    end else if (state_q == S_FRAME && done_ev && byte_cnt_q < 3'd5) begin
      crc_d = crc7_upd(crc_q, spi_tx_q);
    end
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) crc_q <= 7'd0;
    else        crc_q <= crc_d;
  end

  assign crc_byte = {crc_d, 1'b1};
`else
  assign crc_byte = (idx_q == 6'd0) ? 8'h95 :
                    (idx_q == 6'd8) ? 8'h87 : 8'h01;
`endif

  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    resp_valid_d   = 1'b0;
    resp_r1_d      = resp_r1_q;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    spi_start_d    = 1'b0;
    spi_tx_d       = spi_tx_q;
    spi_cs_n_d     = spi_cs_n_q;
    pend_d         = pend_q;
    wait_d         = wait_q;
    byte_cnt_d     = byte_cnt_q;
    poll_cnt_d     = poll_cnt_q;
    idx_d          = idx_q;
    arg_d          = arg_q;
    len_d          = len_q;
    r1_sh_d        = r1_sh_q;
    data_sh_d      = data_sh_q;
    to_sh_d        = to_sh_q;

    // Start is issued the cycle after a byte slot is entered
    if (pend_q) begin
      spi_start_d = 1'b1;
      pend_d      = 1'b0;
      wait_d      = 1'b1;
    end
    if (done_ev) wait_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d          = cmd_index;
          arg_d          = cmd_arg;
          len_d          = cmd_resp_len;
          resp_timeout_d = 1'b0;
          to_sh_d        = 1'b0;
          if (!cmd_resp_len) begin
            resp_data_d = 32'd0;
            data_sh_d   = 32'd0;
          end
          cmd_ready_d = 1'b0;
          spi_cs_n_d  = 1'b0;
          pend_d      = 1'b1;
          byte_cnt_d  = 3'd0;
          poll_cnt_d  = 8'd0;
          if (PRE_BYTES > 0) begin
            state_d  = S_PRE;
            spi_tx_d = 8'hFF;
          end else begin
            state_d  = S_FRAME;
            spi_tx_d = frame_byte(3'd0, cmd_index, cmd_arg, 8'hFF);
          end
        end
      end
      S_PRE: begin
        if (done_ev) begin
          pend_d = 1'b1;
          if (int'(byte_cnt_q) == PRE_BYTES - 1) begin
            state_d    = S_FRAME;
            byte_cnt_d = 3'd0;
            spi_tx_d   = frame_byte(3'd0, idx_q, arg_q, crc_byte);
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            spi_tx_d   = 8'hFF;
          end
        end
      end
      S_FRAME: begin
        if (done_ev) begin
          pend_d = 1'b1;
          if (byte_cnt_q == 3'd5) begin
            state_d    = S_POLL;
            byte_cnt_d = 3'd0;
            spi_tx_d   = 8'hFF;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
            spi_tx_d   = frame_byte(byte_cnt_q + 3'd1, idx_q, arg_q, crc_byte);
          end
        end
      end
      S_POLL: begin
        if (done_ev) begin
          pend_d   = 1'b1;
          spi_tx_d = 8'hFF;
          if (!spi_rx[7]) begin
            r1_sh_d    = spi_rx;
            byte_cnt_d = 3'd0;
            state_d    = len_q ? S_DATA : S_TAIL;
          end else if (int'(poll_cnt_q) == RESP_POLL_MAX - 1) begin
            r1_sh_d = 8'hFF;
            to_sh_d = 1'b1;
            state_d = S_TAIL;
          end else begin
            poll_cnt_d = poll_cnt_q + 8'd1;
          end
        end
      end
      S_DATA: begin
        if (done_ev) begin
          pend_d    = 1'b1;
          spi_tx_d  = 8'hFF;
          data_sh_d = {data_sh_q[23:0], spi_rx};
          if (byte_cnt_q == 3'd3) begin
            state_d = S_TAIL;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      S_TAIL: begin
        if (done_ev) begin
          state_d        = S_DONE;
          spi_cs_n_d     = 1'b1;
          resp_valid_d   = 1'b1;
          resp_r1_d      = r1_sh_q;
          resp_data_d    = data_sh_q;
          resp_timeout_d = to_sh_q;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        spi_cs_n_d  = 1'b1;
        pend_d      = 1'b0;
        wait_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      cmd_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_r1_q      <= 8'hFF;
      resp_data_q    <= 32'd0;
      resp_timeout_q <= 1'b0;
      spi_start_q    <= 1'b0;
      spi_tx_q       <= 8'hFF;
      spi_cs_n_q     <= 1'b1;
      pend_q         <= 1'b0;
      wait_q         <= 1'b0;
      byte_cnt_q     <= 3'd0;
      poll_cnt_q     <= 8'd0;
      idx_q          <= 6'd0;
      arg_q          <= 32'd0;
      len_q          <= 1'b0;
      r1_sh_q        <= 8'hFF;
      data_sh_q      <= 32'd0;
      to_sh_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_r1_q      <= resp_r1_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
      spi_start_q    <= spi_start_d;
      spi_tx_q       <= spi_tx_d;
      spi_cs_n_q     <= spi_cs_n_d;
      pend_q         <= pend_d;
      wait_q         <= wait_d;
      byte_cnt_q     <= byte_cnt_d;
      poll_cnt_q     <= poll_cnt_d;
      idx_q          <= idx_d;
      arg_q          <= arg_d;
      len_q          <= len_d;
      r1_sh_q        <= r1_sh_d;
      data_sh_q      <= data_sh_d;
      to_sh_q        <= to_sh_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_r1      = resp_r1_q;
  assign resp_data    = resp_data_q;
  assign resp_timeout = resp_timeout_q;
  assign spi_start    = spi_start_q;
  assign spi_tx       = spi_tx_q;
  assign spi_cs_n     = spi_cs_n_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: a card/shifter model answers each byte, a queue scoreboard checks wire bytes and responses.
module tb_sd_cmd_sequencer;

  localparam int POLL_MAX = 16;
  localparam int PRE_N    = 1;

  logic        MasterCLK = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_resp_len;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data;
  logic        resp_timeout;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_done;
  logic        spi_cs_n;

  sd_cmd_sequencer #(.RESP_POLL_MAX(POLL_MAX), .PRE_BYTES(PRE_N)) dut (
    .MasterCLK(MasterCLK), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_resp_len(cmd_resp_len),
    .resp_valid(resp_valid), .resp_r1(resp_r1), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .spi_start(spi_start), .spi_tx(spi_tx),
    .spi_rx(spi_rx), .spi_done(spi_done), .spi_cs_n(spi_cs_n)
  );

  always #5 MasterCLK = ~MasterCLK;

  typedef struct {
    logic [7:0]  r1;
    logic [31:0] data;
    logic        to;
    int          nbytes;
  } resp_t;

  resp_t      exp_resp[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         bytes_seen = 0;
  int         gen = 0;
  logic [31:0] model_prev = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Remainder of (message * x^7) mod (x^7 + x^3 + 1) by long division
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [7:0] ref_crc_byte(input logic [5:0] ix, input logic [31:0] a);
`ifdef SD_CRC7_EN
    return {ref_crc7({2'b01, ix, a}), 1'b1};
`else
    return (ix == 6'd0) ? 8'h95 : (ix == 6'd8) ? 8'h87 : 8'h01;
`endif
  endfunction

  // Build the full wire conversation and final response for one command
  task automatic push_model(input logic [5:0] ix, input logic [31:0] a, input logic len,
                            input int nff, input logic [7:0] r1, input logic [31:0] d);
    resp_t e;
    int    polls;
    logic  to;
    logic [7:0] cmd_b;
    cmd_b = {2'b01, ix};
    for (int i = 0; i < PRE_N; i++) begin exp_tx.push_back(8'hFF); rx_q.push_back(8'hFF); end
    exp_tx.push_back(cmd_b);
    exp_tx.push_back(a[31:24]);
    exp_tx.push_back(a[23:16]);
    exp_tx.push_back(a[15:8]);
    exp_tx.push_back(a[7:0]);
    exp_tx.push_back(ref_crc_byte(ix, a));
    for (int i = 0; i < 6; i++) rx_q.push_back(8'hFF);
    to    = (nff >= POLL_MAX);
    polls = to ? POLL_MAX : nff + 1;
    for (int i = 0; i < polls; i++) begin
      exp_tx.push_back(8'hFF);
      rx_q.push_back((i < nff) ? 8'hFF : r1);
    end
    if (len && !to) begin
      for (int i = 0; i < 4; i++) begin
        exp_tx.push_back(8'hFF);
        rx_q.push_back(d[31 - 8*i -: 8]);
      end
    end
    exp_tx.push_back(8'hFF);
    rx_q.push_back(8'hFF);
    e.r1     = to ? 8'hFF : r1;
    e.to     = to;
    e.data   = !len ? 32'd0 : (to ? model_prev : d);
    e.nbytes = PRE_N + 6 + polls + ((len && !to) ? 4 : 0) + 1;
    model_prev = e.data;
    exp_resp.push_back(e);
  endtask

  task automatic drive_cmd(input logic [5:0] ix, input logic [31:0] a, input logic len);
    int t = 0;
    while (!cmd_ready && t < 500) begin @(negedge MasterCLK); t++; end
    chk("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_index = ix; cmd_arg = a; cmd_resp_len = len;
    @(negedge MasterCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_resp.size() != 0 && t < 3000) begin @(negedge MasterCLK); t++; end
    if (exp_resp.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL resp_wait: got no resp_valid, expected %0d pending", exp_resp.size());
      exp_resp.delete(); exp_tx.delete(); rx_q.delete();
    end
    repeat (2) @(negedge MasterCLK);
  endtask

  task automatic run_cmd(input logic [5:0] ix, input logic [31:0] a, input logic len,
                         input int nff, input logic [7:0] r1, input logic [31:0] d);
    push_model(ix, a, len, nff, r1, d);
    drive_cmd(ix, a, len);
    wait_idle();
  endtask

  // Card / byte shifter model
  initial begin : shifter
    int g;
    int dly;
    logic [7:0] rb;
    spi_done = 1'b0;
    spi_rx   = 8'hFF;
    forever begin
      @(negedge MasterCLK);
      spi_done = 1'b0;
      if (Reset && spi_start) begin
        g = gen;
        bytes_seen++;
        chk("cs_low_on_start", spi_cs_n, 1'b0);
        if (exp_tx.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_extra: got %0h expected no byte", spi_tx);
        end else begin
          chk("tx_byte", spi_tx, exp_tx.pop_front());
        end
        rb  = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
        dly = $urandom_range(1, 4);
        repeat (dly) @(negedge MasterCLK);
        if (g == gen && Reset) begin
          spi_rx   = rb;
          spi_done = 1'b1;
        end
      end
    end
  end

  // Response monitor
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge MasterCLK);
      if (Reset && resp_valid) begin
        if (exp_resp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL resp_extra: got r1 %0h expected no response", resp_r1);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_r1", resp_r1, e.r1);
          chk("resp_data", resp_data, e.data);
          chk("resp_timeout", resp_timeout, e.to);
          chk("byte_count", bytes_seen, e.nbytes);
          chk("cs_high_done", spi_cs_n, 1'b1);
        end
        bytes_seen = 0;
        @(negedge MasterCLK);
        chk("valid_one_cycle", resp_valid, 1'b0);
        chk("ready_after_done", cmd_ready, 1'b1);
      end
    end
  end

  initial begin : stim
    int t;
    int busy_bad;
    Reset = 1'b0; cmd_valid = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0; cmd_resp_len = 1'b0;
    repeat (3) @(negedge MasterCLK);
    Reset = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_r1", resp_r1, 8'hFF);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_timeout", resp_timeout, 1'b0);
    chk("rst_spi_start", spi_start, 1'b0);
    chk("rst_spi_tx", spi_tx, 8'hFF);
    chk("rst_spi_cs_n", spi_cs_n, 1'b1);
    @(negedge MasterCLK);

    run_cmd(6'd0, 32'h0000_0000, 1'b0, 1, 8'h01, 32'd0);
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, 0, 8'h01, 32'h0000_01AA);
    run_cmd(6'd58, 32'h0, 1'b1, 40, 8'h00, 32'hDEAD_BEEF);
    chk("cs_high_after_timeout", spi_cs_n, 1'b1);
    run_cmd(6'd55, 32'h0, 1'b0, 0, 8'h01, 32'd0);
    run_cmd(6'd41, 32'h4000_0000, 1'b1, 15, 8'h05, 32'h1234_5678);
    run_cmd(6'd17, 32'h0000_0200, 1'b0, 16, 8'h00, 32'd0);

    // Reset during frame byte 3
    push_model(6'd0, 32'hA5A5_A5A5, 1'b0, 0, 8'h01, 32'd0);
    drive_cmd(6'd0, 32'hA5A5_A5A5, 1'b0);
    t = 0;
    while (bytes_seen < PRE_N + 4 && t < 500) begin @(negedge MasterCLK); t++; end
    chk("reached_frame_byte3", bytes_seen, PRE_N + 4);
    #3 Reset = 1'b0;
    #1;
    chk("abort_cs_n", spi_cs_n, 1'b1);
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    chk("abort_resp_valid", resp_valid, 1'b0);
    gen++;
    exp_tx.delete(); rx_q.delete(); exp_resp.delete();
    bytes_seen = 0; spi_done = 1'b0; model_prev = 32'd0;
    repeat (3) @(negedge MasterCLK);
    Reset = 1'b1;
    @(negedge MasterCLK);
    run_cmd(6'd0, 32'h0, 1'b0, 1, 8'h01, 32'd0);

    // Request held while busy must wait until the current command completes
    push_model(6'd8, 32'h0000_01AA, 1'b1, 2, 8'h01, 32'hCAFE_0001);
    push_model(6'd13, 32'h0000_0000, 1'b0, 0, 8'h00, 32'd0);
    drive_cmd(6'd8, 32'h0000_01AA, 1'b1);
    cmd_valid = 1'b1; cmd_index = 6'd13; cmd_arg = 32'd0; cmd_resp_len = 1'b0;
    busy_bad = 0; t = 0;
    while (!resp_valid && t < 2000) begin
      if (cmd_ready) busy_bad++;
      @(negedge MasterCLK); t++;
    end
    chk("busy_ready_low", busy_bad, 0);
    chk("first_resp_seen", resp_valid, 1'b1);
    @(negedge MasterCLK);
    chk("ready_cycle_after", cmd_ready, 1'b1);
    @(negedge MasterCLK);
    cmd_valid = 1'b0;
    chk("held_cmd_accepted", cmd_ready, 1'b0);
    wait_idle();

    for (int k = 0; k < 40; k++) begin
      logic [5:0]  ix;
      logic [31:0] a;
      logic [31:0] d;
      logic        len;
      logic [7:0]  r1;
      ix  = 6'($urandom_range(0, 63));
      a   = $urandom;
      d   = $urandom;
      len = 1'($urandom_range(0, 1));
      r1  = {1'b0, 7'($urandom_range(0, 127))};
      run_cmd(ix, a, len, $urandom_range(0, 20), r1, d);
    end

    chk("tx_queue_drained", exp_tx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
